// File: rtl/lut_divider_32by16.sv
// ---------------------------------------------------------------------------
// lut_divider_32by16
//
// Iterative unsigned restoring divider: divides a 2*WIDTH-bit dividend (the
// product coming out of the 16x16 LUT multiplier) by a WIDTH-bit divisor.
// It produces one quotient bit per clock and returns both quotient and
// remainder, so a mul -> div round trip recovers the original operands.
//
// Handshake: a start pulse is accepted only in IDLE.
// - The operands are captured on the accepting edge.
// - busy is high while the RUN iterations are in progress.
// - done pulses for exactly one cycle when the results are valid.
// - Results and error flags hold until the next accepted start.
//
// Error fast path: a zero divisor, or a quotient that cannot fit in WIDTH
// bits, goes straight to DONE. busy never rises on this path.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset; aborts any operation
//   start        request, sampled only in IDLE
//   dividend     [2*WIDTH-1:0] numerator, captured on accept
//   divisor      [WIDTH-1:0]   denominator, captured on accept
//   busy         high from the accepting edge until done
//   done         one-cycle pulse, results valid
//   quotient     [WIDTH-1:0] result
//   remainder    [WIDTH-1:0] result
//   div_by_zero  divisor was zero
//   overflow     quotient does not fit in WIDTH bits
// ---------------------------------------------------------------------------
module lut_divider_32by16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WIDTH:0]     p, p_n;         // partial remainder, one guard bit
    logic [WIDTH-1:0]   q, q_n;         // dividend low half shifting out, quotient bits shifting in
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   dvsr, dvsr_n;
    logic [WIDTH-1:0]   quo_n, rem_n;
    logic               dbz_n, ovf_n;

    // Trial value for the current iteration. p stays below the divisor, so
    // its low WIDTH bits are all that matter when shifting in the next bit.
    logic [WIDTH:0]     trial;
    logic               qbit;

    always_comb begin
        state_n = state;
        p_n     = p;
        q_n     = q;
        cnt_n   = cnt;
        dvsr_n  = dvsr;
        quo_n   = quotient;
        rem_n   = remainder;
        dbz_n   = div_by_zero;
        ovf_n   = overflow;
        trial   = {p[WIDTH-1:0], q[WIDTH-1]};
        qbit    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    dvsr_n = divisor;
                    dbz_n  = 1'b0;
                    ovf_n  = 1'b0;
                    quo_n  = '0;
                    rem_n  = '0;
                    if (divisor == '0) begin
                        state_n = DONE;
                        dbz_n   = 1'b1;
                        quo_n   = '1;
                        rem_n   = dividend[WIDTH-1:0];
                    end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                        // The high half already reaches the divisor, so the
                        // quotient needs more than WIDTH bits.
                        state_n = DONE;
                        ovf_n   = 1'b1;
                        quo_n   = '1;
                        rem_n   = '0;
                    end else begin
                        state_n = RUN;
                        p_n     = {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        q_n     = dividend[WIDTH-1:0];
                        cnt_n   = CNT_W'(WIDTH);
                    end
                end
            end

            RUN: begin
                if (trial >= {1'b0, dvsr}) begin
                    p_n  = trial - {1'b0, dvsr};
                    qbit = 1'b1;
                end else begin
                    p_n  = trial;
                    qbit = 1'b0;
                end
                q_n   = {q[WIDTH-2:0], qbit};
                cnt_n = cnt - 1'b1;
                // The last iteration loads the results directly, so they are
                // valid in the same cycle that done is high.
                if (cnt == CNT_W'(1)) begin
                    state_n = DONE;
                    quo_n   = q_n;
                    rem_n   = p_n[WIDTH-1:0];
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            p           <= '0;
            q           <= '0;
            cnt         <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            p           <= p_n;
            q           <= q_n;
            cnt         <= cnt_n;
            dvsr        <= dvsr_n;
            quotient    <= quo_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
            overflow    <= ovf_n;
        end
    end

    // Pure decodes of the state register: no path from any input.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_lut_divider_32by16.sv
// ---------------------------------------------------------------------------
// Self-checking bench for lut_divider_32by16.
//
// Valid/ready semantics of the DUT handshake:
// - start is accepted on a rising edge only while the divider is idle.
// - done is a one-cycle pulse with the results valid.
// - Results hold until the next accepted start.
//
// Timing of the bench:
// - Inputs are driven 1 ns after a rising edge.
// - Outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_lut_divider_32by16;

    localparam int W = 16;

    // ------------------------------------------------------------ clock/reset
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   dividend;
    logic [15:0]   divisor;
    logic          busy;
    logic          done;
    logic [15:0]   quotient;
    logic [15:0]   remainder;
    logic          div_by_zero;
    logic          overflow;

    always #5 clk = ~clk;

    lut_divider_32by16 #(.WIDTH(16), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ------------------------------------------------------------ scoreboard
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model built directly from the arithmetic definition.
    task automatic model(input logic [31:0] a, input logic [15:0] b,
                         output logic [15:0] eq, output logic [15:0] er,
                         output logic edz, output logic eov, output int elat);
        edz = 1'b0;
        eov = 1'b0;
        if (b == 16'd0) begin
            edz = 1'b1; eq = 16'hFFFF; er = a[15:0]; elat = 0;
        end else if ((a / {16'd0, b}) > 32'h0000_FFFF) begin
            eov = 1'b1; eq = 16'hFFFF; er = 16'd0; elat = 0;
        end else begin
            eq = 16'(a / {16'd0, b});
            er = 16'(a % {16'd0, b});
            elat = W;
        end
    endtask

    // ------------------------------------------------------------ driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation from IDLE and collects everything observable.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                          output logic [15:0] rq, output logic [15:0] rr,
                          output logic rdz, output logic rov,
                          output int lat, output int bcnt, output logic after_done);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        rq  = quotient;
        rr  = remainder;
        rdz = div_by_zero;
        rov = overflow;
        tick();
        after_done = done;
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                            input logic [15:0] eq, input logic [15:0] er,
                            input logic edz, input logic eov, input int elat);
        logic [15:0] rq, rr;
        logic        rdz, rov, ad;
        int          lat, bcnt;
        exp_q.push_back(eq);
        run_op(a, b, rq, rr, rdz, rov, lat, bcnt, ad);
        check({tag, " quotient"},  32'(rq), 32'(exp_q.pop_front()));
        check({tag, " remainder"}, 32'(rr), 32'(er));
        check({tag, " div_by_zero"}, 32'(rdz), 32'(edz));
        check({tag, " overflow"},  32'(rov), 32'(eov));
        check({tag, " latency"},   32'(lat), 32'(elat));
        check({tag, " busy cycles"}, 32'(bcnt), 32'(elat));
        check({tag, " done single"}, 32'(ad), 32'd0);
        if (!edz && !eov) begin
            check({tag, " invariant"}, 32'(rq) * 32'(b) + 32'(rr), a);
        end
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        string       name;
        logic [31:0] a;
        logic [15:0] b;
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        logic        eov;
        int          elat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] rq, rr, eq, er;
        logic        rdz, rov, ad, edz, eov;
        int          lat, bcnt, elat, dones;
        logic [31:0] a;
        logic [15:0] b;

        vecs[0] = '{"basic",   32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, W};
        vecs[1] = '{"max_rt",  32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, W};
        vecs[2] = '{"ff_rt",   32'h0000_FE01, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b0, W};
        vecs[3] = '{"dbz",     32'h1234_5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 0};
        vecs[4] = '{"ovf",     32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0};
        vecs[5] = '{"zero",    32'h0000_0000, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b0, W};
        vecs[6] = '{"ovf_eq",  32'h00FF_1234, 16'h00FF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy",      32'(busy), 0);
        check("reset done",      32'(done), 0);
        check("reset quotient",  32'(quotient), 0);
        check("reset remainder", 32'(remainder), 0);
        check("reset dbz",       32'(div_by_zero), 0);
        check("reset ovf",       32'(overflow), 0);

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            check_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er,
                     vecs[i].edz, vecs[i].eov, vecs[i].elat);
        end

        // A second start during RUN is ignored; only one done appears.
        start = 1'b1; dividend = 32'd100; divisor = 16'd7;
        tick();
        start = 1'b0;
        dones = 0;
        for (int c = 1; c < 30; c++) begin
            if (c == 5) begin
                start = 1'b1; dividend = 32'd9; divisor = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                check("ignore quotient",  32'(quotient), 32'd14);
                check("ignore remainder", 32'(remainder), 32'd2);
            end
            tick();
        end
        start = 1'b0;
        check("ignore done count", 32'(dones), 32'd1);

        // Reset in the middle of a run aborts it without a done.
        start = 1'b1; dividend = 32'd100; divisor = 16'd7;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy",      32'(busy), 0);
        check("abort done",      32'(done), 0);
        check("abort quotient",  32'(quotient), 0);
        check("abort remainder", 32'(remainder), 0);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) dones++;
            tick();
        end
        check("abort quiet", 32'(dones), 0);
        check_op("after_abort", 32'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0, W);

        // Held results: the next operation sees the previous values until accept.
        check("held quotient", 32'(quotient), 32'd10);

        // Random normal operations against the model.
        for (int i = 0; i < 1000; i++) begin
            b = 16'($urandom_range(1, 65535));
            a = {16'($urandom_range(0, int'(b) - 1)), 16'($urandom)};
            model(a, b, eq, er, edz, eov, elat);
            check_op("rand", a, b, eq, er, edz, eov, elat);
        end

        // Random mix including error cases.
        for (int i = 0; i < 60; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = {16'($urandom_range(0, 255)), 16'($urandom)};
            model(a, b, eq, er, edz, eov, elat);
            check_op("rand_mix", a, b, eq, er, edz, eov, elat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_divider_32by16.md
Name: lut_divider_32by16

Overview:
- Iterative unsigned restoring divider; the inverse of the 16x16 LUT multiplier path.
- Divides a 32-bit dividend (a multiplier product) by a 16-bit divisor and yields a 16-bit quotient and a 16-bit remainder.
- Sequential: one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier blocks so benches can round-trip mul -> div and recover the operands.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- start  input  1  request; sampled only in IDLE.
- dividend  input  2*WIDTH  numerator; captured when start is accepted.
- divisor  input  WIDTH  denominator; captured when start is accepted.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  single-cycle pulse; results valid.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  error flag; held with the results.
- overflow  output  1  quotient does not fit in WIDTH bits; held with the results.

Behaviour:
- Reset (edge with reset=1): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0; counter and partial remainder cleared.
  - Reset wins over all other inputs and aborts any operation in progress; no done is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 captures the operands.
  - The error flags and quotient/remainder are cleared at E0.
- IDLE exits at E0:
  - divisor==0: go to DONE; div_by_zero=1, quotient={WIDTH{1}}, remainder=dividend[WIDTH-1:0].
  - Else if dividend[2W-1:W] >= divisor: go to DONE; overflow=1, quotient={WIDTH{1}}, remainder=0.
  - Else: go to RUN with partial remainder P=dividend[2W-1:W] (W+1 bits internally), shift register Q=dividend[W-1:0], counter=WIDTH; busy=1.
- RUN, each edge:
  - T = {P[W-1:0], Q[W-1]}.
  - If T >= divisor: P=T-divisor and the quotient bit is 1; else P=T and the quotient bit is 0.
  - Q shifts left, taking in the quotient bit.
  - Counter decrements.
  - Leave for DONE on the edge where the counter reaches 0, i.e. the WIDTH-th RUN edge.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE on the next edge. quotient=Q and remainder=P[W-1:0] are loaded on the edge that enters DONE.
- Latency:
  - Normal operation: done is high in the cycle after edge E0+WIDTH (E16 at the default).
  - Error cases: done is high in the cycle after E0.
- busy is 1 for cycles E0..E0+WIDTH-1 (normal operation). busy stays 0 on the error fast path.
- start is ignored while in RUN or DONE: no queuing, operands not re-sampled.
  - start held high continuously restarts on the first IDLE edge after DONE.
- Outputs are registered. No combinational path from any input to any output.
- All arithmetic is unsigned.
- Invariant for normal results: dividend == quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- Basic: start with dividend=32'h0000_0064, divisor=16'h0007 -> done high 16 cycles after the accepting edge; quotient=16'h000E, remainder=16'h0002, flags 0.
- Max round-trip: dividend=32'hFFFE_0001 (0xFFFF*0xFFFF), divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0. Then dividend=32'h0000_FE01, divisor=16'h00FF -> quotient=16'h00FF, remainder=0.
- Errors:
  - divisor=0, dividend=32'h1234_5678 -> done 1 cycle after accept; div_by_zero=1, quotient=16'hFFFF, remainder=16'h5678, busy never high.
  - dividend=32'h0001_0000, divisor=16'h0001 -> overflow=1, quotient=16'hFFFF, remainder=0.
- Handshake: pulse start with operands (100,7); at cycle 5 assert start with (9,3) -> ignored, result still 14 rem 2; exactly one done pulse.
- Reset mid-run: start (100,7), assert reset at cycle 8 -> next cycle all outputs 0, state IDLE, no done. A fresh start of (50,5) then gives quotient=10, remainder=0 after 16 cycles.
- Random: 1000 random dividend/divisor pairs with dividend[31:16] < divisor -> quotient*divisor+remainder==dividend, remainder<divisor, latency exactly 16.
